uart_rx: RTL
============

Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1 by default, LSB first, idle-high line.
- Pairs with the project's UART transmitter and uses the same fixed CLKS_PER_BIT bit timing, generated by an internal divider counter.
- Deserialises `rx` into parallel bytes and presents each one with a single-cycle valid strobe.
- Reports framing errors and line-break conditions.

Parameters:
- CLKS_PER_BIT, 868: clk_in cycles per bit period; legal range is 4 or more.
- DATA_BITS, 8: data bits per frame; legal range is 5 to 8.

Ports:
- clk_in  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous reset, active-low (0 = reset), sampled on the clk_in rising edge.
- rx  input  1  serial line; asynchronous to clk_in; idles high.
- data_out  output  DATA_BITS  last received byte; holds until the next valid frame.
- data_valid  output  1  one-cycle strobe; data_out is new this cycle.
- framing_error  output  1  one-cycle strobe; the stop bit was sampled low.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset==0 at a clk_in edge) sets:
  - state=IDLE, data_out=0, data_valid=0, framing_error=0, busy=0.
  - bit counter=0, clock counter=0.
  - Both synchroniser flops=1.
- Reset applied mid-frame aborts the frame with no strobe. After release, reception resumes at the next falling edge seen in IDLE.
- Input path: rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s, so there are 2 cycles of input latency.
- Clock counter `cnt` runs 0..CLKS_PER_BIT-1. "Mid-bit" means cnt==(CLKS_PER_BIT-1)/2 using integer division.
- IDLE:
  - cnt=0, busy=0.
  - rx_s==0 moves to START with cnt=0.
- START:
  - cnt increments each cycle.
  - At mid-bit: if rx_s==0, go to DATA with cnt=0 and bit index=0. Sampling points now sit at bit centres.
  - At mid-bit with rx_s==1: glitch. Return to IDLE with no strobe.
- DATA:
  - cnt increments each cycle.
  - At cnt==CLKS_PER_BIT-1: shift rx_s into the shift register MSB side, so the first-received bit ends in bit 0. Then cnt=0 and bit index increments.
  - After DATA_BITS samples, go to STOP.
- STOP:
  - At cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1: on the next edge, data_out=shift register, data_valid=1 for exactly one cycle, go to IDLE.
  - rx_s==0: framing_error=1 for one cycle, data_out unchanged, no data_valid, go to BREAK.
- BREAK:
  - busy=1.
  - Wait for rx_s==1, then go to IDLE.
  - This blocks a held-low line (break) from being decoded as a stream of 0x00 bytes.
- busy is high in START, DATA, STOP and BREAK. It drops in the same cycle as the data_valid or IDLE return.
- data_valid and framing_error are never high together, and neither is high for two consecutive cycles.
- Back-to-back frames: a start bit directly after the stop bit is accepted. IDLE is re-entered half a bit before the stop-bit end, so the next falling edge is always detected.
- Latency: data_valid rises 1 cycle after the stop-bit centre sample. With input at line time 0 = start-bit falling edge, that is approximately 2 + (CLKS_PER_BIT-1)/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles.
- rx changes while busy have no effect except at sample points.

Test Plan (bench uses CLKS_PER_BIT=16, DATA_BITS=8; each bit driven for 16 clk_in cycles):
- Hold reset=0 for 4 cycles with rx=1, then release -> data_out=0x00, data_valid=0, busy=0, framing_error=0.
- Send frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> exactly one data_valid pulse with data_out=0xA5, rising 2+7+144+1=154 cycles after the start edge. busy falls in the same cycle.
- Send 0x00, 0xFF and 0x3C back-to-back with no idle gap -> three data_valid pulses, data_out sequence 0x00, 0xFF, 0x3C, no framing_error.
- Pulse rx low for 3 cycles, then high -> busy high briefly, returns to IDLE, no data_valid, no framing_error.
- Send 0x55 with stop bit 0, hold rx low 40 more bit times, then rx=1 -> one framing_error pulse, data_out keeps its previous value, no further strobes, busy falls about 2 cycles after rx returns high.
- Assert reset=0 midway through the data bits of 0x81, release, then send 0x42 -> no strobe for the aborted frame, a single data_valid with data_out=0x42.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1-style serial receiver: samples a synchronised rx line at bit centres and
// presents each received word with a one-cycle strobe, flagging bad stop bits.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bitIdx_q, bitIdx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dataOut_q, dataOut_d;
  logic                 dataValid_q, dataValid_d;
  logic                 framingErr_q, framingErr_d;
  logic                 rxMeta_q, rxSync_q;

  // Two-flop synchroniser; both flops reset to the idle-high line level.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bitIdx_q     <= '0;
      shift_q      <= '0;
      dataOut_q    <= '0;
      dataValid_q  <= 1'b0;
      framingErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitIdx_q     <= bitIdx_d;
      shift_q      <= shift_d;
      dataOut_q    <= dataOut_d;
      dataValid_q  <= dataValid_d;
      framingErr_q <= framingErr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bitIdx_d     = bitIdx_q;
    shift_d      = shift_q;
    dataOut_d    = dataOut_q;
    dataValid_d  = 1'b0;
    framingErr_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxSync_q) state_d = S_START;
      end
      // Re-check the start bit at its centre so later samples land mid-bit.
      S_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          state_d  = rxSync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          shift_d  = {rxSync_q, shift_q[DATA_BITS-1:1]};
          bitIdx_d = bitIdx_q + 1'b1;
          if (bitIdx_q == BIT_LAST) state_d = S_STOP;
        end
      end
      // Leaving at the stop-bit centre leaves half a bit to catch the next start.
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxSync_q) begin
            dataOut_d   = shift_q;
            dataValid_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            framingErr_d = 1'b1;
            state_d      = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxSync_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign data_out      = dataOut_q;
  assign data_valid    = dataValid_q;
  assign framing_error = framingErr_q;
  assign busy          = (state_q != S_IDLE);

endmodule
